// File: rtl/oscope_capture_engine.sv
// Triggered N-channel capture engine: decimates ADC slots into a circular RAM, waits for an
// edge or forced trigger, fills the post-trigger window, then streams the frame oldest-first as bytes.
module oscope_capture_engine #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 512,
  parameter int DEC_W    = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic                       arm,
  input  logic                       force_trig,
  input  logic [CH_W-1:0]            trig_ch,
  input  logic [SAMPLE_W-1:0]        trig_level,
  input  logic                       trig_rising,
  input  logic [AW-1:0]              pretrig,
  input  logic [DEC_W-1:0]           decim,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       triggered,
  output logic                       done
);
  localparam int SLOT_W = NUM_CH * SAMPLE_W;
  localparam int NBYTES = NUM_CH * 2;
  localparam int BW     = $clog2(NBYTES);
  localparam logic [AW-1:0]    ONE_A    = 1;
  localparam logic [AW:0]      ONE_R    = 1;
  localparam logic [DEC_W-1:0] ONE_D    = 1;
  localparam logic [BW-1:0]    ONE_B    = 1;
  localparam logic [AW:0]      N_SLOTS  = (AW+1)'(DEPTH);
  localparam logic [BW-1:0]    LAST_B   = BW'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READ} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d, trig_addr_q, trig_addr_d;
  logic [AW:0]         ro_cnt_q, ro_cnt_d;
  logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d, decim_q, decim_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d, lvl_q, lvl_d;
  logic                prev_vld_q, prev_vld_d, triggered_q, triggered_d, done_q, done_d;
  logic                prime_q, prime_d, slot_vld_q, slot_vld_d, rising_q, rising_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [BW-1:0]       byte_idx_q, byte_idx_d;
  logic [CH_W-1:0]     trig_ch_q, trig_ch_d;
  logic [AW-1:0]       pretrig_q, pretrig_d;

  logic [SLOT_W-1:0]   mem [DEPTH];
  logic [SLOT_W-1:0]   rd_data_q;
  logic                we, capturing, acc_smp, edge_hit, out_acc;
  logic [CH_W-1:0]     tc;
  logic [SAMPLE_W-1:0] cur_smp;

  assign tc      = (int'(trig_ch_q) < NUM_CH) ? trig_ch_q : '0;
  assign cur_smp = SAMPLE_W'(sample_data >> (int'(tc) * SAMPLE_W));
  assign edge_hit = prev_vld_q && (rising_q ? (prev_q < lvl_q && cur_smp >= lvl_q)
                                            : (prev_q > lvl_q && cur_smp <= lvl_q));
  assign out_acc = slot_vld_q && out_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    ro_cnt_d    = ro_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    triggered_d = triggered_q;
    done_d      = 1'b0;
    prime_d     = prime_q;
    slot_vld_d  = slot_vld_q;
    slot_d      = slot_q;
    byte_idx_d  = byte_idx_q;
    trig_ch_d   = trig_ch_q;
    lvl_d       = lvl_q;
    rising_d    = rising_q;
    pretrig_d   = pretrig_q;
    decim_d     = decim_q;
    we          = 1'b0;
    capturing   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    acc_smp     = capturing && sample_valid && (dec_cnt_q == decim_q);

    if (capturing && sample_valid) dec_cnt_d = acc_smp ? '0 : dec_cnt_q + ONE_D;
    if (acc_smp) begin
      we         = 1'b1;
      wr_ptr_d   = wr_ptr_q + ONE_A;
      prev_d     = cur_smp;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (arm) begin
        trig_ch_d   = trig_ch;
        lvl_d       = trig_level;
        rising_d    = trig_rising;
        pretrig_d   = pretrig;
        decim_d     = decim;
        wr_ptr_d    = '0;
        cnt_d       = '0;
        dec_cnt_d   = '0;
        prev_vld_d  = 1'b0;
        triggered_d = 1'b0;
        state_d     = (pretrig == '0) ? S_WAIT : S_PRE;
      end
      S_PRE: if (acc_smp) begin
        cnt_d = cnt_q + ONE_A;
        if (cnt_q + ONE_A == pretrig_q) state_d = S_WAIT;
      end
      S_WAIT: if (acc_smp && (force_trig || edge_hit)) begin
        trig_addr_d = wr_ptr_q;
        triggered_d = 1'b1;
        cnt_d       = '0;
        // ~pretrig == DEPTH-1-pretrig: zero means the trigger slot completes the frame
        if (~pretrig_q == '0) begin
          state_d  = S_READ;
          rd_ptr_d = wr_ptr_q - pretrig_q;
          ro_cnt_d = '0;
          prime_d  = 1'b0;
        end else begin
          state_d = S_POST;
        end
      end
      S_POST: if (acc_smp) begin
        cnt_d = cnt_q + ONE_A;
        if (cnt_q + ONE_A == ~pretrig_q) begin
          state_d  = S_READ;
          rd_ptr_d = trig_addr_q - pretrig_q;
          ro_cnt_d = '0;
          prime_d  = 1'b0;
        end
      end
      S_READ: begin
        // One-cycle wait lets rd_data_q settle on the start slot; afterwards every slot
        // has >= 2 bytes, so the next slot's read is always ready by the last byte.
        if (!slot_vld_q) begin
          if (prime_q) begin
            slot_d     = rd_data_q;
            slot_vld_d = 1'b1;
            byte_idx_d = '0;
            rd_ptr_d   = rd_ptr_q + ONE_A;
            ro_cnt_d   = ro_cnt_q + ONE_R;
          end else begin
            prime_d = 1'b1;
          end
        end else if (out_acc) begin
          if (byte_idx_q != LAST_B) begin
            byte_idx_d = byte_idx_q + ONE_B;
          end else if (ro_cnt_q == N_SLOTS) begin
            slot_vld_d  = 1'b0;
            done_d      = 1'b1;
            triggered_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            slot_d     = rd_data_q;
            byte_idx_d = '0;
            rd_ptr_d   = rd_ptr_q + ONE_A;
            ro_cnt_d   = ro_cnt_q + ONE_R;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      ro_cnt_q    <= '0;
      dec_cnt_q   <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      prime_q     <= 1'b0;
      slot_vld_q  <= 1'b0;
      slot_q      <= '0;
      byte_idx_q  <= '0;
      trig_ch_q   <= '0;
      lvl_q       <= '0;
      rising_q    <= 1'b0;
      pretrig_q   <= '0;
      decim_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      ro_cnt_q    <= ro_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      prime_q     <= prime_d;
      slot_vld_q  <= slot_vld_d;
      slot_q      <= slot_d;
      byte_idx_q  <= byte_idx_d;
      trig_ch_q   <= trig_ch_d;
      lvl_q       <= lvl_d;
      rising_q    <= rising_d;
      pretrig_q   <= pretrig_d;
      decim_q     <= decim_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= sample_data;
    rd_data_q <= mem[rd_ptr_q];
  end

  always_comb begin
    int ch_sel;
    logic [SAMPLE_W-1:0] smp;
    logic [15:0] ext;
    ch_sel = int'(byte_idx_q >> 1);
    smp    = SAMPLE_W'(slot_q >> (ch_sel * SAMPLE_W));
    ext    = 16'(smp);
    out_data = '0;
    if (slot_vld_q) out_data = byte_idx_q[0] ? ext[15:8] : ext[7:0];
  end

  assign out_valid = slot_vld_q;
  assign busy      = (state_q != S_IDLE);
  assign triggered = triggered_q;
  assign done      = done_q;
endmodule

// File: tb/tb_oscope_capture_engine.sv
// Directed bench for oscope_capture_engine (2 ch, 12-bit, 16 slots); expected frame bytes go
// into a queue at stimulus time and a negedge monitor pops them on every accepted byte.
module tb_oscope_capture_engine;
  localparam int NUM_CH = 2, SAMPLE_W = 12, DEPTH = 16, DEC_W = 16;
  localparam int FRAME_BYTES = DEPTH * NUM_CH * 2;

  logic        clk, reset_n, sample_valid, arm, force_trig, trig_rising, out_ready;
  logic [23:0] sample_data;
  logic [0:0]  trig_ch;
  logic [11:0] trig_level;
  logic [3:0]  pretrig;
  logic [15:0] decim;
  logic [7:0]  out_data;
  logic        out_valid, busy, triggered, done;

  int errors = 0, checks = 0;
  bit rdy_rand = 0;
  logic [7:0] exp_q [$];

  oscope_capture_engine #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .DEC_W(DEC_W)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .arm(arm), .force_trig(force_trig), .trig_ch(trig_ch), .trig_level(trig_level),
    .trig_rising(trig_rising), .pretrig(pretrig), .decim(decim), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .triggered(triggered), .done(done));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always begin
    @(posedge clk); #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard monitor
  int nbytes = 0;
  bit done_exp = 0, stall = 0;
  logic [7:0] stall_data, exp_b;
  always @(negedge clk) begin
    if (!reset_n) begin
      nbytes = 0; done_exp = 0; stall = 0;
    end else begin
      if (done_exp || done) begin
        chk("done_pulse", {31'd0, done}, {31'd0, done_exp});
        if (done) chk("busy_with_done", {31'd0, busy}, 32'd0);
      end
      done_exp = 0;
      if (stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {24'd0, out_data}, {24'd0, stall_data});
      end
      stall = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'd1, 32'd0);
        end else begin
          exp_b = exp_q.pop_front();
          chk($sformatf("byte%0d", nbytes), {24'd0, out_data}, {24'd0, exp_b});
        end
        nbytes++;
        if (nbytes == FRAME_BYTES) begin done_exp = 1; nbytes = 0; end
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic cfg(input int lvl, input int pre, input int dec);
    trig_ch = 1'b0; trig_rising = 1'b1;
    trig_level = 12'(lvl); pretrig = 4'(pre); decim = 16'(dec);
  endtask

  task automatic pulse_arm; arm = 1; tick; arm = 0; endtask

  // Expected frame: ch0 = base + step*j, ch1 = 0xABC
  task automatic push_frame(input int base, input int step);
    for (int j = 0; j < DEPTH; j++) begin
      logic [11:0] v;
      v = 12'(base + step * j);
      exp_q.push_back(v[7:0]);
      exp_q.push_back({4'd0, v[11:8]});
      exp_q.push_back(8'hBC);
      exp_q.push_back(8'h0A);
    end
  endtask

  // mode 0: ch0 ramps 10*k; mode 1: ch0 held at 200. force_trig from strobe force_at on.
  task automatic run_strobes(input int start, input int n, input int mode, input int force_at);
    for (int k = start; k < start + n; k++) begin
      logic [11:0] v;
      v = (mode == 1) ? 12'd200 : 12'(10 * k);
      sample_data = {12'hABC, v};
      force_trig = (force_at >= 0) && (k >= force_at);
      sample_valid = 1; tick;
      sample_valid = 0; tick;
    end
    force_trig = 0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (busy === 1'b1 && t < 3000) begin @(negedge clk); t++; end
    chk({name, "_timeout"}, {31'd0, busy}, 32'd0);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    tick;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_out_data"}, {24'd0, out_data}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_triggered"}, {31'd0, triggered}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int t;
    reset_n = 0; sample_valid = 0; sample_data = '0; arm = 0; force_trig = 0; out_ready = 1;
    cfg(100, 4, 0);
    repeat (3) tick;
    chk_idle_outputs("reset");
    reset_n = 1; tick;

    // 1: ramp, rising at 100, pretrig 4 -> frame ch0 = 60,70,...
    cfg(100, 4, 0); pulse_arm;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    push_frame(60, 10);
    run_strobes(0, 8, 0, -1);
    chk("t1_not_trig", {31'd0, triggered}, 32'd0);
    run_strobes(8, 32, 0, -1);
    wait_done("t1");

    // 2: decim=2, lvl=150 -> accepted 20,50,80,110 pre; trigger at 170; frame 50+30j
    cfg(150, 4, 2); pulse_arm;
    push_frame(50, 30);
    run_strobes(0, 60, 0, -1);
    wait_done("t2");

    // 3: constant 200 never edges; force from strobe 20
    cfg(100, 4, 0); pulse_arm;
    push_frame(200, 0);
    run_strobes(0, 22, 1, 20);
    chk("t3_triggered", {31'd0, triggered}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    run_strobes(22, 20, 1, -1);
    wait_done("t3");

    // 4: pretrig 0, lvl 250 -> ring wraps while waiting; slot 0 = 250
    cfg(250, 0, 0); pulse_arm;
    push_frame(250, 10);
    run_strobes(0, 50, 0, -1);
    wait_done("t4");

    // 5: test 1 with random backpressure
    rdy_rand = 1;
    cfg(100, 4, 0); pulse_arm;
    push_frame(60, 10);
    run_strobes(0, 40, 0, -1);
    wait_done("t5");
    rdy_rand = 0; tick;

    // 6a: reset during post-fill
    cfg(100, 4, 0); pulse_arm;
    run_strobes(0, 14, 0, -1);
    chk("t6a_triggered", {31'd0, triggered}, 32'd1);
    reset_n = 0; tick;
    chk_idle_outputs("t6a");
    tick; reset_n = 1; tick;

    // 6b: reset during readout
    cfg(100, 4, 0); pulse_arm;
    push_frame(60, 10);
    run_strobes(0, 24, 0, -1);
    t = 0;
    while (out_valid !== 1'b1 && t < 200) begin tick; t++; end
    chk("t6b_readout_seen", {31'd0, out_valid}, 32'd1);
    repeat (5) tick;
    reset_n = 0; tick;
    chk_idle_outputs("t6b");
    exp_q.delete();
    tick; reset_n = 1; tick;

    // 6c: clean frame; a second arm with different config mid-capture must be ignored
    cfg(100, 4, 0); pulse_arm;
    push_frame(60, 10);
    run_strobes(0, 5, 0, -1);
    cfg(50, 0, 1); pulse_arm;
    run_strobes(5, 35, 0, -1);
    wait_done("t6c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
